// File: rtl/acc_controller_mc.sv
// Multicycle controller for the accumulator CPU: multi-word fetch, decode,
// memory read/write with wait states, execute, conditional jump and halt.
module acc_controller_mc #(
  parameter int OPCODE_W = 4,
  parameter int IR_PARTS = 2,
  parameter int ALU_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] upcode,
  input  logic                acZero,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcSrc,
  output logic                memAddressSel,
  output logic                ACdataSel,
  output logic                memRead,
  output logic                memWrite,
  output logic                ACwrite,
  output logic                ACread,
  output logic [ALU_W-1:0]    ALUcommand,
  output logic [IR_PARTS-1:0] IRwrite,
  output logic                halted
);

  localparam int KW = (IR_PARTS > 1) ? $clog2(IR_PARTS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(IR_PARTS - 1);

  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(8);

  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_NOT  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_PASS = ALU_W'(4);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_HALT
  } state_t;

  state_t              state, state_n;
  logic [KW-1:0]       k, k_n;
  logic [OPCODE_W-1:0] op_q;

  function automatic logic [ALU_W-1:0] alu_cmd(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      OP_LDA:  return ALU_PASS;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  // Opcode captured at decode so EXEC does not depend on the IR staying put.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) op_q <= upcode;
  end

  always_comb begin
    state_n       = state;
    k_n           = k;
    pcWrite       = 1'b0;
    pcSrc         = 1'b0;
    memAddressSel = 1'b0;
    ACdataSel     = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    ACwrite       = 1'b0;
    ACread        = 1'b0;
    ALUcommand    = '0;
    IRwrite       = '0;
    halted        = 1'b0;
    // Outputs are forced low while reset is held, whatever state is latched.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          memRead = 1'b1;
          if (memReady) begin
            IRwrite = IR_PARTS'(1) << k;
            pcWrite = 1'b1;
            if (k == KLAST) begin
              k_n     = '0;
              state_n = S_DECODE;
            end else begin
              k_n = k + KW'(1);
            end
          end
        end
        S_DECODE: begin
          case (upcode)
            OP_ADD, OP_SUB, OP_AND, OP_LDA: state_n = S_MEM_RD;
            OP_NOT: state_n = S_EXEC;
            OP_STA: state_n = S_MEM_WR;
            OP_HLT: state_n = S_HALT;
            OP_JMP: begin
              pcWrite = 1'b1;
              pcSrc   = 1'b1;
              state_n = S_FETCH;
            end
            OP_JZ: begin
              pcWrite = acZero;
              pcSrc   = acZero;
              state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
          endcase
        end
        S_MEM_RD: begin
          memRead       = 1'b1;
          memAddressSel = 1'b1;
          if (memReady) state_n = S_EXEC;
        end
        S_EXEC: begin
          ALUcommand = alu_cmd(op_q);
          ACwrite    = 1'b1;
          if (op_q == OP_LDA) begin
            ACdataSel = 1'b1;
          end else begin
            ACread = 1'b1;
          end
          state_n = S_FETCH;
        end
        S_MEM_WR: begin
          memWrite      = 1'b1;
          memAddressSel = 1'b1;
          ACread        = 1'b1;
          if (memReady) state_n = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule
